write_back_ctrl: RTL and testbench
==================================

# write_back_ctrl

Parametrised result-drain engine for the systolic array. When `start` is asserted it captures the ARRAY_SIZE×ARRAY_SIZE accumulator tile, narrows each element from ACC_W to DATA_W bits and streams the elements one per accepted beat to the result memory port over a valid/ready handshake. Addresses are generated with a configurable base and row stride. It sits between the array's accumulator outputs and the result SRAM write port, and replaces the fixed-width, handshake-less write-back stage.

## Interface
- ACC_W, 32, accumulator element width (must be ≥ DATA_W)
- DATA_W, 16, memory word width
- ARRAY_SIZE, 2, tile edge; tile holds ARRAY_SIZE*ARRAY_SIZE elements
- ADDR_W, 10, memory address width
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin drain; sampled only in IDLE
- base_addr  in  ADDR_W  address of element 0; latched on start
- row_stride  in  ADDR_W  address step between row starts; latched on start
- data_in  in  ARRAY_SIZE*ARRAY_SIZE*ACC_W  tile; element k = data_in[k*ACC_W +: ACC_W], k = row*ARRAY_SIZE+col
- busy  out  1  high while not IDLE
- done  out  1  one-cycle pulse after the last beat is accepted
- mem_valid  out  1  beat valid
- mem_ready  in  1  memory accepts beat
- mem_addr  out  ADDR_W  beat address
- mem_data  out  DATA_W  narrowed element

## Operation
- FSM: IDLE → SEND → DONE → IDLE.
- IDLE: when start=1, latch data_in, base_addr and row_stride. Clear row/col to 0, set row_base=base_addr, go to SEND.
- SEND:
  - mem_valid=1; mem_addr=row_base+col; mem_data=narrow(element[row*N+col]).
  - On mem_valid&&mem_ready, advance col. When col==N-1: col←0, row←row+1, row_base←row_base+row_stride.
  - When the last element (k=N*N-1) is accepted, go to DONE.
- DONE: done=1 for one cycle, mem_valid=0, then return to IDLE.
- Order is row-major, element 0 (LSB slice) first.
- Address arithmetic is modulo 2^ADDR_W. Wrap-around is silent.
- Narrowing defaults to truncation: mem_data = element[DATA_W-1:0]. See Configuration for the saturating alternative.
- start outside IDLE is ignored. data_in changes after capture do not affect the output.
- Reset, including mid-drain: state IDLE, busy=0, done=0, mem_valid=0, mem_addr=0, mem_data=0, counters 0. The aborted tile is discarded and no done pulse is issued.

## Timing
- All outputs are registered.
- start sampled high at edge T: busy=1 and mem_valid=1 with element 0 from T+1.
- With mem_ready held high, element k is presented in cycle T+1+k, done is high in cycle T+1+N*N, and busy falls in cycle T+2+N*N.
- While mem_valid=1 and mem_ready=0, mem_addr and mem_data are held stable. Beats are never dropped or repeated.
- mem_ready while mem_valid=0 has no effect.
- Earliest next start is sampled in the cycle after done; throughput is 1 beat/cycle.

## Configuration
- WB_SAT_EN defined: narrowing is signed saturation of the ACC_W value to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. In-range values pass through unchanged.
- WB_SAT_EN undefined: plain truncation to the low DATA_W bits. No saturation logic is synthesised.

## Structure
- Package wb_pkg holds the FSM state enum (WB_IDLE, WB_SEND, WB_DONE) and a localparam for element count N*N together with its counter width $clog2(N*N).
- One sub-module: wb_narrow (combinational, ACC_W→DATA_W, truncate or saturate under WB_SAT_EN). It is instantiated once on the selected element.

## Test plan
Configuration: ARRAY_SIZE=2, ACC_W=32, DATA_W=16, ADDR_W=10.
- Free-flowing drain:
  - Stimulus: elements 1,2,3,4; base 0x010; stride 2; mem_ready=1.
  - Response: beats (0x010,1), (0x011,2), (0x012,3), (0x013,4) in cycles T+1..T+4. done at T+5, busy low at T+6.
- Address wrap:
  - Stimulus: base 0x3FE, stride 8.
  - Response: addresses 0x3FE, 0x3FF, 0x006, 0x007.
- Backpressure:
  - Stimulus: mem_ready low for 3 cycles while element 1 is presented.
  - Response: addr/data held for those cycles, no skipped or duplicate beat, done delayed by exactly 3 cycles.
- Narrowing:
  - 0x0001_2345: 0x7FFF with WB_SAT_EN, 0x2345 without.
  - 0xFFFF_8000: 0x8000 in both builds.
  - 0xFFFE_0000: 0x8000 with WB_SAT_EN, 0x0000 without.
- Ignored inputs:
  - Stimulus: start pulsed and data_in changed during SEND.
  - Response: the original tile drains unchanged, exactly one done pulse.
- Reset mid-drain:
  - Stimulus: rst_n low after beat 1.
  - Response: all outputs 0, no done pulse. The next start drains a full 4-beat sequence from element 0.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg: shared types and constants for the write-back drain engine.
//   wb_state_e          : FSM states (WB_IDLE, WB_SEND, WB_DONE)
//   WB_ARRAY_SIZE_DEF   : default tile edge
//   WB_NUM_ELEM         : elements per default tile (N*N)
//   WB_CNT_W            : element counter width for the default tile
//   wb_cnt_w()          : element counter width for an arbitrary tile edge
package wb_pkg;

  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_SEND = 2'd1,
    WB_DONE = 2'd2
  } wb_state_e;

  localparam int WB_ARRAY_SIZE_DEF = 2;
  localparam int WB_NUM_ELEM       = WB_ARRAY_SIZE_DEF * WB_ARRAY_SIZE_DEF;
  localparam int WB_CNT_W          = $clog2(WB_NUM_ELEM);

  // A 1x1 tile still needs a 1-bit counter to keep vectors legal.
  function automatic int wb_cnt_w(input int n);
    return (n * n > 1) ? $clog2(n * n) : 1;
  endfunction

endpackage

// File: rtl/wb_narrow.sv
// wb_narrow: combinational ACC_W -> DATA_W element narrowing.
//   acc_i  [ACC_W-1:0]  : accumulator element (two's complement)
//   data_o [DATA_W-1:0] : narrowed memory word
// Build option WB_SAT_EN: when defined, signed saturation to the DATA_W
// range; when undefined, plain truncation to the low DATA_W bits.
module wb_narrow #(
  parameter int ACC_W  = 32,
  parameter int DATA_W = 16
) (
  input  logic [ACC_W-1:0]  acc_i,
  output logic [DATA_W-1:0] data_o
);

`ifdef WB_SAT_EN
  // The value fits in DATA_W signed bits exactly when every bit from the
  // target sign position upward is a copy of the same value.
  logic [ACC_W-DATA_W:0] hi_bits;
  logic                  in_range;

  assign hi_bits  = acc_i[ACC_W-1:DATA_W-1];
  assign in_range = (&hi_bits) | ~(|hi_bits);

  always_comb begin
    data_o = acc_i[DATA_W-1:0];
    if (!in_range) begin
      if (acc_i[ACC_W-1]) begin
        data_o = {1'b1, {(DATA_W-1){1'b0}}};
      end else begin
        data_o = {1'b0, {(DATA_W-1){1'b1}}};
      end
    end
  end
`else
  assign data_o = acc_i[DATA_W-1:0];

  // Upper accumulator bits are intentionally dropped in the truncating build.
  generate
    if (ACC_W > DATA_W) begin : g_trunc
      logic unused_hi;
      assign unused_hi = ^acc_i[ACC_W-1:DATA_W];
    end
  endgenerate
`endif

endmodule

// File: rtl/write_back_ctrl.sv
// write_back_ctrl: drains an ARRAY_SIZE x ARRAY_SIZE accumulator tile to the
// result memory, one narrowed element per accepted valid/ready beat, in
// row-major order with base address + row stride addressing.
//   clk, rst_n     : clock, asynchronous active-low reset
//   start_i        : begin a drain (only honoured in IDLE)
//   base_addr_i    : address of element 0, latched on start
//   row_stride_i   : address step between row starts, latched on start
//   data_in_i      : tile, element k at [k*ACC_W +: ACC_W], k = row*N+col
//   busy_o         : high while a drain is in progress
//   done_o         : one-cycle pulse after the last beat is accepted
//   mem_valid_o    : beat valid
//   mem_ready_i    : memory accepts beat
//   mem_addr_o     : beat address (modulo 2^ADDR_W)
//   mem_data_o     : narrowed element
// Build option WB_SAT_EN selects saturating narrowing (see wb_narrow).
//
// state    | meaning
// WB_IDLE  | waiting for start; outputs quiet
// WB_SEND  | presenting beats; advances on mem_valid && mem_ready
// WB_DONE  | done pulse; return to IDLE
module write_back_ctrl
  import wb_pkg::*;
#(
  parameter int ACC_W      = 32,
  parameter int DATA_W     = 16,
  parameter int ARRAY_SIZE = WB_ARRAY_SIZE_DEF,
  parameter int ADDR_W     = 10
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   start_i,
  input  logic [ADDR_W-1:0]                      base_addr_i,
  input  logic [ADDR_W-1:0]                      row_stride_i,
  input  logic [ARRAY_SIZE*ARRAY_SIZE*ACC_W-1:0] data_in_i,
  output logic                                   busy_o,
  output logic                                   done_o,
  output logic                                   mem_valid_o,
  input  logic                                   mem_ready_i,
  output logic [ADDR_W-1:0]                      mem_addr_o,
  output logic [DATA_W-1:0]                      mem_data_o
);

  localparam int NUM_ELEM = ARRAY_SIZE * ARRAY_SIZE;
  localparam int CNT_W    = wb_cnt_w(ARRAY_SIZE);
  localparam int COL_W    = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;

  localparam logic [CNT_W-1:0] LAST_ELEM = CNT_W'(NUM_ELEM - 1);
  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(ARRAY_SIZE - 1);

  wb_state_e         state_q, state_d;
  logic [ACC_W-1:0]  tile_q [NUM_ELEM];
  logic [CNT_W-1:0]  elem_q, elem_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              capture;

  logic [CNT_W-1:0]  elem_nxt;
  logic [ACC_W-1:0]  sel_acc;
  logic [DATA_W-1:0] narrow_data;

  // Output data is registered, so the narrower always works one beat ahead:
  // in IDLE it sees element 0 straight off the input bus (the tile is being
  // captured on that same edge), otherwise the element after the current one.
  // At the last element the index wraps to 0; that value is never loaded.
  assign elem_nxt = elem_q + CNT_W'(1);
  assign sel_acc  = (state_q == WB_IDLE) ? data_in_i[ACC_W-1:0] : tile_q[elem_nxt];

  wb_narrow #(
    .ACC_W  (ACC_W),
    .DATA_W (DATA_W)
  ) u_narrow (
    .acc_i  (sel_acc),
    .data_o (narrow_data)
  );

  always_comb begin
    state_d    = state_q;
    elem_d     = elem_q;
    col_d      = col_q;
    row_base_d = row_base_q;
    stride_d   = stride_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    valid_d    = valid_q;
    addr_d     = addr_q;
    data_d     = data_q;
    capture    = 1'b0;

    unique case (state_q)
      WB_IDLE: begin
        if (start_i) begin
          capture    = 1'b1;
          state_d    = WB_SEND;
          elem_d     = '0;
          col_d      = '0;
          row_base_d = base_addr_i;
          stride_d   = row_stride_i;
          busy_d     = 1'b1;
          valid_d    = 1'b1;
          addr_d     = base_addr_i;
          data_d     = narrow_data;
        end
      end

      WB_SEND: begin
        if (valid_q && mem_ready_i) begin
          if (elem_q == LAST_ELEM) begin
            state_d = WB_DONE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            elem_d = elem_nxt;
            data_d = narrow_data;
            if (col_q == LAST_COL) begin
              col_d      = '0;
              row_base_d = row_base_q + stride_q;
              addr_d     = row_base_d;
            end else begin
              col_d  = col_q + COL_W'(1);
              addr_d = row_base_q + ADDR_W'(col_d);
            end
          end
        end
      end

      WB_DONE: begin
        state_d = WB_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = WB_IDLE;
        busy_d  = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= WB_IDLE;
      elem_q     <= '0;
      col_q      <= '0;
      row_base_q <= '0;
      stride_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      for (int k = 0; k < NUM_ELEM; k++) begin
        tile_q[k] <= '0;
      end
    end else begin
      state_q    <= state_d;
      elem_q     <= elem_d;
      col_q      <= col_d;
      row_base_q <= row_base_d;
      stride_q   <= stride_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      valid_q    <= valid_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      if (capture) begin
        for (int k = 0; k < NUM_ELEM; k++) begin
          tile_q[k] <= data_in_i[k*ACC_W +: ACC_W];
        end
      end
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign mem_valid_o = valid_q;
  assign mem_addr_o  = addr_q;
  assign mem_data_o  = data_q;

endmodule

// File: tb/tb_write_back_ctrl.sv
// tb_write_back_ctrl: directed self-checking bench for write_back_ctrl
// (ARRAY_SIZE=2, ACC_W=32, DATA_W=16, ADDR_W=10). Inputs change and outputs
// are sampled on the falling clock edge. Expected narrowing results follow
// the WB_SAT_EN build option.
module tb_write_back_ctrl;

  localparam int ACC_W  = 32;
  localparam int DATA_W = 16;
  localparam int N      = 2;
  localparam int ADDR_W = 10;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  start = 1'b0;
  logic [ADDR_W-1:0]     base_addr = '0;
  logic [ADDR_W-1:0]     row_stride = '0;
  logic [N*N*ACC_W-1:0]  data_in = '0;
  logic                  busy, done, mem_valid;
  logic                  mem_ready = 1'b1;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_data;

  int passed = 0;
  int total = 0;
  int done_cnt = 0;
  int done_snap;

  write_back_ctrl #(
    .ACC_W      (ACC_W),
    .DATA_W     (DATA_W),
    .ARRAY_SIZE (N),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start),
    .base_addr_i  (base_addr),
    .row_stride_i (row_stride),
    .data_in_i    (data_in),
    .busy_o       (busy),
    .done_o       (done),
    .mem_valid_o  (mem_valid),
    .mem_ready_i  (mem_ready),
    .mem_addr_o   (mem_addr),
    .mem_data_o   (mem_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done) done_cnt++;
  end

`ifdef WB_SAT_EN
  localparam logic [15:0] EXP_POS_OVF = 16'h7FFF;
  localparam logic [15:0] EXP_NEG_OVF = 16'h8000;
`else
  localparam logic [15:0] EXP_POS_OVF = 16'h2345;
  localparam logic [15:0] EXP_NEG_OVF = 16'h0000;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic set_tile(input logic [31:0] e0, input logic [31:0] e1,
                          input logic [31:0] e2, input logic [31:0] e3);
    data_in = {e3, e2, e1, e0};
  endtask

  // Pulse start for one edge; returns at the falling edge of cycle T+1.
  task automatic go(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] stride);
    base_addr  = base;
    row_stride = stride;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  // Checks the beat presented this cycle, then moves to the next cycle.
  task automatic beat(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    chk({tag, ".valid"}, 32'(mem_valid), 32'd1);
    chk({tag, ".addr"}, 32'(mem_addr), 32'(a));
    chk({tag, ".data"}, 32'(mem_data), 32'(d));
    chk({tag, ".done"}, 32'(done), 32'd0);
    @(negedge clk);
  endtask

  task automatic finish_drain(input string tag);
    chk({tag, ".done_hi"}, 32'(done), 32'd1);
    chk({tag, ".valid_lo"}, 32'(mem_valid), 32'd0);
    chk({tag, ".busy_in_done"}, 32'(busy), 32'd1);
    @(negedge clk);
    chk({tag, ".done_lo"}, 32'(done), 32'd0);
    chk({tag, ".busy_lo"}, 32'(busy), 32'd0);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".done"}, 32'(done), 32'd0);
    chk({tag, ".valid"}, 32'(mem_valid), 32'd0);
    chk({tag, ".addr"}, 32'(mem_addr), 32'd0);
    chk({tag, ".data"}, 32'(mem_data), 32'd0);
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk_quiet("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Free-flowing drain
    set_tile(32'd1, 32'd2, 32'd3, 32'd4);
    go(10'h010, 10'd2);
    chk("free.busy", 32'(busy), 32'd1);
    beat("free.b0", 10'h010, 16'd1);
    beat("free.b1", 10'h011, 16'd2);
    beat("free.b2", 10'h012, 16'd3);
    beat("free.b3", 10'h013, 16'd4);
    finish_drain("free");

    // Address wrap modulo 2^10
    set_tile(32'h11, 32'h22, 32'h33, 32'h44);
    go(10'h3FE, 10'd8);
    beat("wrap.b0", 10'h3FE, 16'h11);
    beat("wrap.b1", 10'h3FF, 16'h22);
    beat("wrap.b2", 10'h006, 16'h33);
    beat("wrap.b3", 10'h007, 16'h44);
    finish_drain("wrap");

    // Narrowing
    set_tile(32'h0001_2345, 32'hFFFF_8000, 32'hFFFE_0000, 32'h0000_0005);
    go(10'h000, 10'd4);
    beat("narrow.pos_ovf", 10'h000, EXP_POS_OVF);
    beat("narrow.min",     10'h001, 16'h8000);
    beat("narrow.neg_ovf", 10'h004, EXP_NEG_OVF);
    beat("narrow.small",   10'h005, 16'h0005);
    finish_drain("narrow");

    // Backpressure: ready low for 3 cycles while element 1 is presented
    set_tile(32'd10, 32'd20, 32'd30, 32'd40);
    go(10'h100, 10'd4);
    beat("bp.b0", 10'h100, 16'd10);
    mem_ready = 1'b0;
    chk("bp.b1_first.addr", 32'(mem_addr), 32'h101);
    chk("bp.b1_first.data", 32'(mem_data), 32'd20);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp.hold.valid", 32'(mem_valid), 32'd1);
      chk("bp.hold.addr", 32'(mem_addr), 32'h101);
      chk("bp.hold.data", 32'(mem_data), 32'd20);
      chk("bp.hold.done", 32'(done), 32'd0);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    beat("bp.b2", 10'h104, 16'd30);
    beat("bp.b3", 10'h105, 16'd40);
    finish_drain("bp");

    // mem_ready toggling while idle has no effect
    mem_ready = 1'b0;
    @(negedge clk);
    mem_ready = 1'b1;
    @(negedge clk);
    chk("idle_ready.valid", 32'(mem_valid), 32'd0);
    chk("idle_ready.busy", 32'(busy), 32'd0);

    // Ignored start and data_in changes during SEND
    set_tile(32'd5, 32'd6, 32'd7, 32'd8);
    done_snap = done_cnt;
    go(10'h020, 10'd1);
    beat("ign.b0", 10'h020, 16'd5);
    start = 1'b1;
    set_tile(32'd99, 32'd98, 32'd97, 32'd96);
    base_addr = 10'h300;
    beat("ign.b1", 10'h021, 16'd6);
    start = 1'b0;
    beat("ign.b2", 10'h021, 16'd7);
    beat("ign.b3", 10'h022, 16'd8);
    finish_drain("ign");
    @(negedge clk);
    chk("ign.no_restart", 32'(busy), 32'd0);
    chk("ign.one_done", 32'(done_cnt - done_snap), 32'd1);

    // Reset mid-drain
    set_tile(32'h101, 32'h102, 32'h103, 32'h104);
    go(10'h040, 10'd2);
    beat("rst.b0", 10'h040, 16'h101);
    done_snap = done_cnt;
    rst_n = 1'b0;
    #1;
    chk_quiet("rst.async");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_quiet("rst.after");
    chk("rst.no_done", 32'(done_cnt - done_snap), 32'd0);
    set_tile(32'h201, 32'h202, 32'h203, 32'h204);
    go(10'h050, 10'd2);
    beat("rst.r0", 10'h050, 16'h201);
    beat("rst.r1", 10'h051, 16'h202);
    beat("rst.r2", 10'h052, 16'h203);
    beat("rst.r3", 10'h053, 16'h204);
    finish_drain("rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
